// File: rtl/fft_pkg.sv
// Shared definitions for the FFT control path: scheduler state encoding and
// the width helpers that size address and twiddle buses from the FFT size.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam int DEFAULT_LOG2_POINTS = 4;
  localparam int DEFAULT_BPU_LATENCY = 6;

  function automatic int addr_width(input int log2_points);
    return log2_points;
  endfunction

  function automatic int tw_width(input int log2_points);
    return log2_points - 1;
  endfunction

endpackage

// File: rtl/bfly_scheduler_buffer.sv
// Fixed-length shift-register delay line; reset clears every tap so that
// no stale valid bit can emerge after a reset.
module buffer #(
  parameter int vector_size   = 1,
  parameter int buffer_length = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [vector_size-1:0] data_in,
  output logic [vector_size-1:0] data_out
);

  logic [vector_size-1:0] taps [buffer_length];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < buffer_length; i++) taps[i] <= '0;
    end else begin
      taps[0] <= data_in;
      for (int i = 1; i < buffer_length; i++) taps[i] <= taps[i-1];
    end
  end

  assign data_out = taps[buffer_length-1];

endmodule

// File: rtl/bfly_scheduler.sv
// In-place radix-2 DIT FFT scheduler: issues butterfly operand/twiddle
// addresses per stage and replays them as write-back addresses after the BPU latency.
module bfly_scheduler
  import fft_pkg::*;
#(
  parameter int LOG2_POINTS = DEFAULT_LOG2_POINTS,
  parameter int BPU_LATENCY = DEFAULT_BPU_LATENCY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [LOG2_POINTS-1:0] stage,
  output logic                   rd_en,
  output logic [LOG2_POINTS-1:0] rd_addr_a,
  output logic [LOG2_POINTS-1:0] rd_addr_b,
  output logic [LOG2_POINTS-2:0] tw_addr,
  output logic                   wr_en,
  output logic [LOG2_POINTS-1:0] wr_addr_c,
  output logic [LOG2_POINTS-1:0] wr_addr_d
);

  localparam int AW = addr_width(LOG2_POINTS);
  localparam int TW = tw_width(LOG2_POINTS);
  localparam int KW = LOG2_POINTS - 1;
  localparam int DW = $clog2(BPU_LATENCY + 1);
  localparam int VW = 2 * AW + 1;

  state_t        state, state_n;
  logic [AW-1:0] stage_q, stage_n;
  logic [KW-1:0] k_q, k_n;
  logic [DW-1:0] drain_q, drain_n;

  logic [AW-1:0] k_ext, half, mask, low, addr_a, tw_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      stage_q <= '0;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      state   <= state_n;
      stage_q <= stage_n;
      k_q     <= k_n;
      drain_q <= drain_n;
    end
  end

  always_comb begin
    state_n = state;
    stage_n = stage_q;
    k_n     = k_q;
    drain_n = drain_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = ISSUE;
          stage_n = '0;
          k_n     = '0;
          drain_n = '0;
        end
      end
      ISSUE: begin
        if (k_q == '1) begin
          state_n = DRAIN;
          drain_n = '0;
        end else begin
          k_n = k_q + KW'(1);
        end
      end
      DRAIN: begin
        // Hold off the next stage until every write of this stage has landed.
        if (drain_q == DW'(BPU_LATENCY - 1)) begin
          if (stage_q == AW'(LOG2_POINTS - 1)) begin
            state_n = DONE;
          end else begin
            state_n = ISSUE;
            stage_n = stage_q + AW'(1);
            k_n     = '0;
          end
        end else begin
          drain_n = drain_q + DW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        stage_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand A index is k with a zero bit inserted at position s; B sets that bit.
  always_comb begin
    k_ext   = AW'(k_q);
    half    = AW'(1) << stage_q;
    mask    = half - AW'(1);
    low     = k_ext & mask;
    addr_a  = ((k_ext & ~mask) << 1) | low;
    tw_full = low << (AW'(TW) - stage_q);
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign stage     = stage_q;
  assign rd_en     = (state == ISSUE);
  assign rd_addr_a = rd_en ? addr_a : '0;
  assign rd_addr_b = rd_en ? (addr_a | half) : '0;
  assign tw_addr   = rd_en ? tw_full[TW-1:0] : '0;

  buffer #(
    .vector_size  (VW),
    .buffer_length(BPU_LATENCY)
  ) u_wb_delay (
    .clk     (clk),
    .reset   (reset),
    .data_in ({rd_en, rd_addr_a, rd_addr_b}),
    .data_out({wr_en, wr_addr_c, wr_addr_d})
  );

endmodule

// File: tb/tb_bfly_scheduler.sv
// Directed bench for bfly_scheduler: hand vectors, a cycle model of the
// schedule, and reset/start corner cases on default and small configurations.
module tb_bfly_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;

  always #5 clk = ~clk;

  logic       busy0, done0, rd0, wr0;
  logic [3:0] stage0, a0, b0, c0, d0;
  logic [2:0] tw0;

  logic       busy1, done1, rd1, wr1;
  logic [2:0] stage1, a1, b1, c1, d1;
  logic [1:0] tw1;

  bfly_scheduler #(.LOG2_POINTS(4), .BPU_LATENCY(6)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
    .stage(stage0), .rd_en(rd0), .rd_addr_a(a0), .rd_addr_b(b0), .tw_addr(tw0),
    .wr_en(wr0), .wr_addr_c(c0), .wr_addr_d(d0)
  );

  bfly_scheduler #(.LOG2_POINTS(3), .BPU_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .stage(stage1), .rd_en(rd1), .rd_addr_a(a1), .rd_addr_b(b1), .tw_addr(tw1),
    .wr_en(wr1), .wr_addr_c(c1), .wr_addr_d(d1)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] stage;
    logic       rd;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] tw;
    logic       wr;
    logic [7:0] c;
    logic [7:0] d;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic obs_t mk(input bit bu, input bit dn, input int st, input bit r,
                              input int a, input int b, input int tw, input bit w,
                              input int c, input int d);
    obs_t o;
    o.busy = bu; o.done = dn; o.stage = 8'(st);
    o.rd = r; o.a = 8'(a); o.b = 8'(b); o.tw = 8'(tw);
    o.wr = w; o.c = 8'(c); o.d = 8'(d);
    return o;
  endfunction

  function automatic obs_t obs0();
    return mk(busy0, done0, int'(stage0), rd0, int'(a0), int'(b0), int'(tw0),
              wr0, int'(c0), int'(d0));
  endfunction

  function automatic obs_t obs1();
    return mk(busy1, done1, int'(stage1), rd1, int'(a1), int'(b1), int'(tw1),
              wr1, int'(c1), int'(d1));
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("busy=%0d done=%0d stage=%0d rd=%0d a=%0d b=%0d tw=%0d wr=%0d c=%0d d=%0d",
                     o.busy, o.done, o.stage, o.rd, o.a, o.b, o.tw, o.wr, o.c, o.d);
  endfunction

  // Reference schedule for a transform whose start was sampled at edge 0.
  function automatic obs_t exp_obs(input int n, input int lg, input int lat);
    obs_t o;
    int p2, per, donec, s, off, k, half, j, a, m;
    o = '0;
    p2 = 1 << (lg - 1);
    per = p2 + lat;
    donec = lg * per + 1;
    if (n >= 1 && n <= donec) begin
      o.busy = 1'b1;
      if (n == donec) begin
        o.done = 1'b1;
        o.stage = 8'(lg - 1);
      end else begin
        s = (n - 1) / per;
        off = (n - 1) % per;
        o.stage = 8'(s);
        if (off < p2) begin
          k = off; half = 1 << s; j = k % half;
          a = ((k >> s) << (s + 1)) | j;
          o.rd = 1'b1; o.a = 8'(a); o.b = 8'(a + half);
          o.tw = 8'(j << (lg - 1 - s));
        end
      end
    end
    m = n - lat;
    if (m >= 1 && m < donec) begin
      s = (m - 1) / per;
      off = (m - 1) % per;
      if (off < p2) begin
        k = off; half = 1 << s; j = k % half;
        a = ((k >> s) << (s + 1)) | j;
        o.wr = 1'b1; o.c = 8'(a); o.d = 8'(a + half);
      end
    end
    return o;
  endfunction

  task automatic checkOutput(input string name, input int n, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s @cycle %0d: got %s | expected %s", name, n, fmt(act), fmt(exp));
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int sel);
    @(negedge clk);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Starts a transform and checks cycles 1..ncyc; optional starts while busy
  // (cycles 5 and 30) and a back-to-back restart in the cycle after done.
  task automatic runSweep(input int sel, input int lg, input int lat, input int ncyc,
                          input bit poke, input bit b2b,
                          output int writes, output int done_at, output int hazards);
    int pending, last_stage, donec, rel;
    obs_t act;
    bit s;
    donec = lg * ((1 << (lg - 1)) + lat) + 1;
    pending = 0; last_stage = -1; writes = 0; done_at = -1; hazards = 0;
    applyStimulus(sel);
    for (int n = 1; n <= ncyc; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      s = (poke && (n == 5 || n == 30)) || (b2b && n == donec + 1);
      if (sel == 0) start0 = s; else start1 = s;
      act = (sel == 0) ? obs0() : obs1();
      rel = (b2b && n > donec + 1) ? n - (donec + 1) : n;
      checkOutput($sformatf("dut%0d_schedule", sel), n, act, exp_obs(rel, lg, lat));
      if (sel == 0) begin
        for (int i = 0; i < vecs.size(); i++)
          if (vecs[i].cyc == n) checkOutput("vector", n, act, vecs[i].exp);
      end
      if (act.wr) begin
        writes++;
        pending--;
      end
      if (act.rd) begin
        if (int'(act.stage) != last_stage && pending != 0) hazards++;
        last_stage = int'(act.stage);
        pending++;
      end
      if (act.done) done_at = n;
    end
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  initial begin
    int writes, done_at, hazards;

    vecs.push_back('{1,  mk(1, 0, 0, 1, 0,  1,  0, 0, 0,  0)});
    vecs.push_back('{2,  mk(1, 0, 0, 1, 2,  3,  0, 0, 0,  0)});
    vecs.push_back('{7,  mk(1, 0, 0, 1, 12, 13, 0, 1, 0,  1)});
    vecs.push_back('{8,  mk(1, 0, 0, 1, 14, 15, 0, 1, 2,  3)});
    vecs.push_back('{9,  mk(1, 0, 0, 0, 0,  0,  0, 1, 4,  5)});
    vecs.push_back('{14, mk(1, 0, 0, 0, 0,  0,  0, 1, 14, 15)});
    vecs.push_back('{15, mk(1, 0, 1, 1, 0,  2,  0, 0, 0,  0)});
    vecs.push_back('{16, mk(1, 0, 1, 1, 1,  3,  4, 0, 0,  0)});
    vecs.push_back('{29, mk(1, 0, 2, 1, 0,  4,  0, 0, 0,  0)});
    vecs.push_back('{48, mk(1, 0, 3, 1, 5,  13, 5, 0, 0,  0)});
    vecs.push_back('{49, mk(1, 0, 3, 1, 6,  14, 6, 1, 0,  8)});
    vecs.push_back('{56, mk(1, 0, 3, 0, 0,  0,  0, 1, 7,  15)});
    vecs.push_back('{57, mk(1, 1, 3, 0, 0,  0,  0, 0, 0,  0)});
    vecs.push_back('{58, mk(0, 0, 0, 0, 0,  0,  0, 0, 0,  0)});

    $display("[TB] reset and idle");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("idle_dut0", i, obs0(), '0);
      checkOutput("idle_dut1", i, obs1(), '0);
      @(posedge clk);
      #1;
    end

    $display("[TB] reset in cycle 20");
    runSweep(0, 4, 6, 20, 1'b0, 1'b0, writes, done_at, hazards);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      checkOutput("post_reset_quiet", i, obs0(), '0);
      @(posedge clk);
      #1;
    end

    $display("[TB] full transform with starts while busy");
    runSweep(0, 4, 6, 64, 1'b1, 1'b0, writes, done_at, hazards);
    checkValue("dut0_write_count", writes, 32);
    checkValue("dut0_done_cycle", done_at, 57);
    checkValue("dut0_stage_hazards", hazards, 0);

    $display("[TB] small config with back-to-back start");
    runSweep(1, 3, 1, 36, 1'b0, 1'b1, writes, done_at, hazards);
    checkValue("dut1_write_count", writes, 24);
    checkValue("dut1_last_done_cycle", done_at, 33);
    checkValue("dut1_stage_hazards", hazards, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
